// File: rtl/macc_sequencer.sv
// macc_sequencer: walks C = A x B in row-major order. For every C element it
// issues A/B reads across the inner dimension, then steers the accumulator
// (acc_clr/acc_en) MAC_LAT cycles later and writes the finished sum to C.
module macc_sequencer #(
  parameter int ADDR_MSB     = 11,
  parameter int IDX_SIZE_MSB = 3,
  parameter int MAC_LAT      = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [IDX_SIZE_MSB:0] m_size,
  input  logic [IDX_SIZE_MSB:0] k_size,
  input  logic [IDX_SIZE_MSB:0] n_size,
  input  logic                  stall,
  output logic                  rd_en,
  output logic [ADDR_MSB:0]     a_addr,
  output logic [ADDR_MSB:0]     b_addr,
  output logic                  acc_en,
  output logic                  acc_clr,
  output logic                  c_wr,
  output logic [ADDR_MSB:0]     c_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = ADDR_MSB + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Largest index for a log2 size; sizes at or beyond the address width
  // saturate to all ones, which is the aliasing case software must avoid.
  function automatic logic [AW-1:0] size_max(input logic [IDX_SIZE_MSB:0] sz);
    logic [AW:0] one_sh;
    logic [AW:0] mx;
    one_sh = {{AW{1'b0}}, 1'b1} << sz;
    mx     = one_sh - 1'b1;
    return mx[AW-1:0];
  endfunction

  // Linearized address (hi << sh) | lo, truncated to the address width.
  function automatic logic [AW-1:0] lin_addr(input logic [AW-1:0] hi,
                                             input logic [AW-1:0] lo,
                                             input logic [IDX_SIZE_MSB:0] sh);
    return (hi << sh) | lo;
  endfunction

  state_t state_q, state_d;

  logic [IDX_SIZE_MSB:0] ms_q, ms_d;
  logic [IDX_SIZE_MSB:0] ks_q, ks_d;
  logic [IDX_SIZE_MSB:0] ns_q, ns_d;

  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic [AW-1:0] k_q, k_d;

  // Side-band pipeline: one entry per read issue, travelling with the
  // MAC datapath so the accumulator controls line up with the products.
  logic [MAC_LAT-1:0] sb_vld_q, sb_vld_d;
  logic [MAC_LAT-1:0] sb_first_q, sb_first_d;
  logic [MAC_LAT-1:0] sb_last_q, sb_last_d;
  logic [AW-1:0]      sb_caddr_q [MAC_LAT];
  logic [AW-1:0]      sb_caddr_d [MAC_LAT];

  logic          wr_pend_q, wr_pend_d;
  logic [AW-1:0] c_addr_q, c_addr_d;

  logic          issue;
  logic          k_last, j_last, i_last;
  logic [AW-1:0] k_max, j_max, i_max;

  // Issue qualifier and wrap detection for the i/j/k walk.
  always_comb begin
    issue  = (state_q == S_RUN) && !stall;
    k_max  = size_max(ks_q);
    j_max  = size_max(ns_q);
    i_max  = size_max(ms_q);
    k_last = (k_q == k_max);
    j_last = (j_q == j_max);
    i_last = (i_q == i_max);
  end

  // Next-state logic for the FSM, counters, side-band pipe and C write.
  always_comb begin
    state_d    = state_q;
    ms_d       = ms_q;
    ks_d       = ks_q;
    ns_d       = ns_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    sb_vld_d   = sb_vld_q;
    sb_first_d = sb_first_q;
    sb_last_d  = sb_last_q;
    sb_caddr_d = sb_caddr_q;
    wr_pend_d  = wr_pend_q;
    c_addr_d   = c_addr_q;

    case (state_q)
      S_IDLE: begin
        // Stall does not block a start; sizes are only sampled here.
        if (start) begin
          ms_d    = m_size;
          ks_d    = k_size;
          ns_d    = n_size;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (k_last) begin
            k_d = '0;
            if (j_last) begin
              j_d = '0;
              if (i_last) begin
                i_d     = '0;
                state_d = S_DRAIN;
              end else begin
                i_d = i_q + 1'b1;
              end
            end else begin
              j_d = j_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // The pending write (if any) goes out in this same non-stalled cycle.
        if (!stall && (sb_vld_q == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!stall) begin
      for (int s = MAC_LAT - 1; s >= 1; s--) begin
        sb_vld_d[s]   = sb_vld_q[s-1];
        sb_first_d[s] = sb_first_q[s-1];
        sb_last_d[s]  = sb_last_q[s-1];
        sb_caddr_d[s] = sb_caddr_q[s-1];
      end
      sb_vld_d[0]   = issue;
      sb_first_d[0] = (k_q == '0);
      sb_last_d[0]  = k_last;
      sb_caddr_d[0] = lin_addr(i_q, j_q, ns_q);

      // A completed sum leaving the pipe is written on the next free cycle.
      wr_pend_d = sb_vld_q[MAC_LAT-1] && sb_last_q[MAC_LAT-1];
      if (sb_vld_q[MAC_LAT-1] && sb_last_q[MAC_LAT-1]) begin
        c_addr_d = sb_caddr_q[MAC_LAT-1];
      end
    end
  end

  // Control state: reset abandons any in-flight work.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ms_q      <= '0;
      ks_q      <= '0;
      ns_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      sb_vld_q  <= '0;
      wr_pend_q <= 1'b0;
      c_addr_q  <= '0;
    end else begin
      state_q   <= state_d;
      ms_q      <= ms_d;
      ks_q      <= ks_d;
      ns_q      <= ns_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      sb_vld_q  <= sb_vld_d;
      wr_pend_q <= wr_pend_d;
      c_addr_q  <= c_addr_d;
    end
  end

  // Side-band payload: qualified by sb_vld_q, so it needs no reset.
  always_ff @(posedge CLK) begin
    sb_first_q <= sb_first_d;
    sb_last_q  <= sb_last_d;
    sb_caddr_q <= sb_caddr_d;
  end

  // Output decode; stall masks every strobe while addresses hold.
  always_comb begin
    rd_en   = issue;
    a_addr  = lin_addr(i_q, k_q, ks_q);
    b_addr  = lin_addr(k_q, j_q, ns_q);
    acc_en  = sb_vld_q[MAC_LAT-1] && !stall;
    acc_clr = sb_vld_q[MAC_LAT-1] && sb_first_q[MAC_LAT-1] && !stall;
    c_wr    = wr_pend_q && !stall;
    c_addr  = c_addr_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE) && !stall;
  end

endmodule
